// File: rtl/eco32_eth_desc_queue_if.sv
// Ring event bus bundle for the ethernet descriptor queue.
// ul_* carries CPU commands in, dl_* carries events back out.
interface eco32_eth_desc_queue_if;
  logic        ul_eve_stb;
  logic [7:0]  ul_eve_cmd;
  logic [35:0] ul_eve_ptr;
  logic        ul_eve_ack;

  logic        dl_eve_stb;
  logic [7:0]  dl_eve_cmd;
  logic [7:0]  dl_eve_dev;
  logic [35:0] dl_eve_ptr;
  logic        dl_eve_ack;

  modport master (
    output ul_eve_stb,
    output ul_eve_cmd,
    output ul_eve_ptr,
    input  ul_eve_ack,
    input  dl_eve_stb,
    input  dl_eve_cmd,
    input  dl_eve_dev,
    input  dl_eve_ptr,
    output dl_eve_ack
  );

  modport slave (
    input  ul_eve_stb,
    input  ul_eve_cmd,
    input  ul_eve_ptr,
    output ul_eve_ack,
    output dl_eve_stb,
    output dl_eve_cmd,
    output dl_eve_dev,
    output dl_eve_ptr,
    input  dl_eve_ack
  );
endinterface

// File: rtl/eco32_eth_desc_queue.sv
// Ethernet buffer-descriptor engine: RX/TX pointer FIFOs fed by
// CPU events, plus a one-deep event slot for completions/status.
module eco32_eth_desc_queue #(
  parameter int         RX_DEPTH_LOG = 4,
  parameter int         TX_DEPTH_LOG = 4,
  parameter int         PTR_W        = 36,
  parameter logic [7:0] EVE_DEST_RST = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  eco32_eth_desc_queue_if.slave eve,
  output logic             rx_ptr_stb,
  output logic [PTR_W-1:0] rx_ptr,
  input  logic             rx_ptr_ack,
  output logic             tx_ptr_stb,
  output logic [PTR_W-1:0] tx_ptr,
  input  logic             tx_ptr_ack,
  input  logic             rx_done_stb,
  input  logic [35:0]      rx_done_ptr,
  output logic             rx_done_ack,
  input  logic             tx_done_stb,
  input  logic [35:0]      tx_done_ptr,
  output logic             tx_done_ack
);

  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int RXC_W    = RX_DEPTH_LOG + 1;
  localparam int TXC_W    = TX_DEPTH_LOG + 1;

  localparam logic [RX_DEPTH_LOG-1:0] RX_P1   = 1;
  localparam logic [TX_DEPTH_LOG-1:0] TX_P1   = 1;
  localparam logic [RXC_W-1:0]        RX_C1   = 1;
  localparam logic [TXC_W-1:0]        TX_C1   = 1;
  localparam logic [RXC_W-1:0]        RX_FULL = RXC_W'(RX_DEPTH);
  localparam logic [TXC_W-1:0]        TX_FULL = TXC_W'(TX_DEPTH);

  localparam logic [7:0] CMD_ADD_RX   = 8'h01;
  localparam logic [7:0] CMD_ADD_TX   = 8'h02;
  localparam logic [7:0] CMD_GET_STAT = 8'h03;
  localparam logic [7:0] CMD_SET_DEST = 8'h04;

  localparam logic [7:0] EVE_RX_DONE  = 8'h11;
  localparam logic [7:0] EVE_TX_DONE  = 8'h12;
  localparam logic [7:0] EVE_STATUS   = 8'h13;

  logic rsx;
  assign rsx = rst | soft_rst;

  // RX FIFO state
  logic [PTR_W-1:0]        rx_mem_q [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] rx_wr_q, rx_wr_d;
  logic [RX_DEPTH_LOG-1:0] rx_rd_q, rx_rd_d;
  logic [RXC_W-1:0]        rx_cnt_q, rx_cnt_d;
  logic                    rx_full, rx_push, rx_pop;

  // TX FIFO state
  logic [PTR_W-1:0]        tx_mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] tx_wr_q, tx_wr_d;
  logic [TX_DEPTH_LOG-1:0] tx_rd_q, tx_rd_d;
  logic [TXC_W-1:0]        tx_cnt_q, tx_cnt_d;
  logic                    tx_full, tx_push, tx_pop;

  // Event slot and control state
  logic        dl_stb_q, dl_stb_d;
  logic [7:0]  dl_cmd_q, dl_cmd_d;
  logic [7:0]  dl_dev_q, dl_dev_d;
  logic [35:0] dl_ptr_q, dl_ptr_d;
  logic        pend_q, pend_d;

  // Command decode
  logic is_add_rx, is_add_tx, is_get_stat, is_set_dest;
  logic ul_stall, ul_ack;
  logic stat_acc, dest_acc;

  // Slot load selection
  logic        load_en;
  logic        sel_stat, sel_rx, sel_tx;
  logic [35:0] stat_word;

  assign rx_full = (rx_cnt_q == RX_FULL);
  assign tx_full = (tx_cnt_q == TX_FULL);

  assign is_add_rx   = (eve.ul_eve_cmd == CMD_ADD_RX);
  assign is_add_tx   = (eve.ul_eve_cmd == CMD_ADD_TX);
  assign is_get_stat = (eve.ul_eve_cmd == CMD_GET_STAT);
  assign is_set_dest = (eve.ul_eve_cmd == CMD_SET_DEST);

  // Backpressure: only queue-bound and status commands can stall
  always_comb begin
    ul_stall = 1'b0;
    unique case (1'b1)
      is_add_rx:   ul_stall = rx_full;
      is_add_tx:   ul_stall = tx_full;
      is_get_stat: ul_stall = pend_q;
      default:     ul_stall = 1'b0;
    endcase
  end

  assign ul_ack   = eve.ul_eve_stb & ~ul_stall & ~rsx;
  assign rx_push  = ul_ack & is_add_rx;
  assign tx_push  = ul_ack & is_add_tx;
  assign stat_acc = ul_ack & is_get_stat;
  assign dest_acc = ul_ack & is_set_dest;

  assign eve.ul_eve_ack = ul_ack;

  assign rx_ptr_stb = (rx_cnt_q != '0);
  assign tx_ptr_stb = (tx_cnt_q != '0);
  assign rx_ptr     = rx_mem_q[rx_rd_q];
  assign tx_ptr     = tx_mem_q[tx_rd_q];
  assign rx_pop     = rx_ptr_stb & rx_ptr_ack & ~rsx;
  assign tx_pop     = tx_ptr_stb & tx_ptr_ack & ~rsx;

  // RX FIFO pointer and occupancy update
  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_wr_d = rx_wr_q + RX_P1;
    if (rx_pop)  rx_rd_d = rx_rd_q + RX_P1;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_C1;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_C1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // TX FIFO pointer and occupancy update
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) tx_wr_d = tx_wr_q + TX_P1;
    if (tx_pop)  tx_rd_d = tx_rd_q + TX_P1;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_C1;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_C1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // FIFO storage; emptied logically by the count reset
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= eve.ul_eve_ptr[PTR_W-1:0];
    if (tx_push) tx_mem_q[tx_wr_q] <= eve.ul_eve_ptr[PTR_W-1:0];
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rsx) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign stat_word = {18'd0, tx_full, rx_full,
                      8'(tx_cnt_q), 8'(rx_cnt_q)};

  // Slot refills when empty or drained this cycle
  assign load_en  = (~dl_stb_q | eve.dl_eve_ack) & ~rsx;
  assign sel_stat = load_en & pend_q;
  assign sel_rx   = load_en & ~pend_q & rx_done_stb;
  assign sel_tx   = load_en & ~pend_q & ~rx_done_stb & tx_done_stb;

  assign rx_done_ack = sel_rx;
  assign tx_done_ack = sel_tx;

  // Next contents of the outgoing event slot
  always_comb begin
    dl_stb_d = dl_stb_q & ~eve.dl_eve_ack;
    dl_cmd_d = dl_cmd_q;
    dl_ptr_d = dl_ptr_q;
    unique case (1'b1)
      sel_stat: begin
        dl_stb_d = 1'b1;
        dl_cmd_d = EVE_STATUS;
        dl_ptr_d = stat_word;
      end
      sel_rx: begin
        dl_stb_d = 1'b1;
        dl_cmd_d = EVE_RX_DONE;
        dl_ptr_d = rx_done_ptr;
      end
      sel_tx: begin
        dl_stb_d = 1'b1;
        dl_cmd_d = EVE_TX_DONE;
        dl_ptr_d = tx_done_ptr;
      end
      default: begin
        dl_cmd_d = dl_cmd_q;
      end
    endcase
  end

  // Status request flag and event destination
  always_comb begin
    pend_d   = pend_q;
    dl_dev_d = dl_dev_q;
    if (sel_stat)      pend_d = 1'b0;
    else if (stat_acc) pend_d = 1'b1;
    if (dest_acc) dl_dev_d = eve.ul_eve_ptr[7:0];
  end

  // Event slot and control registers
  always_ff @(posedge clk) begin
    if (rsx) begin
      dl_stb_q <= 1'b0;
      dl_cmd_q <= '0;
      dl_ptr_q <= '0;
      dl_dev_q <= EVE_DEST_RST;
      pend_q   <= 1'b0;
    end else begin
      dl_stb_q <= dl_stb_d;
      dl_cmd_q <= dl_cmd_d;
      dl_ptr_q <= dl_ptr_d;
      dl_dev_q <= dl_dev_d;
      pend_q   <= pend_d;
    end
  end

  assign eve.dl_eve_stb = dl_stb_q;
  assign eve.dl_eve_cmd = dl_cmd_q;
  assign eve.dl_eve_dev = dl_dev_q;
  assign eve.dl_eve_ptr = dl_ptr_q;

endmodule
